mem_port_arbiter: RTL and testbench

- Shares the single-ported unified RAM between the fetch stage (instruction reads) and the mem stage (data reads/writes) of the 5-stage pipeline.
- Registered FSM grants one requester at a time; data has priority, bounded by an instruction-starvation limit.
- Completion is signalled through per-requester wait lines that the pipeline latches and hazard logic consume (the stall source for LW/SW).

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: RAM handshake states, the arbiter's FSM
// encoding and the machine word type.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter: the fetch stage
// (instruction reads) and the mem stage (data reads/writes).
interface mem_port_arbiter_if;
   import cpu_types_pkg::*;

   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;
   logic  dREN;
   logic  dWEN;
   word_t daddr;
   word_t dstore;
   logic  dwait;
   word_t dload;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      output iwait, iload, dwait, dload
   );

   modport tb (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  iwait, iload, dwait, dload
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified RAM between instruction fetch
// and data accesses. Data has priority unless an instruction read has been
// passed over STARVE_MAX times in a row. The FSM state is the only grant
// source; RAM-side outputs and wait lines are decoded from it
// combinationally, so a completion is seen in the same cycle as ACCESS.
// Optional build macro MEM_PORT_ARBITER_PERF_EN adds the icount/dcount
// completion counters.
module mem_port_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned CNT_W      = 4
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
`ifdef MEM_PORT_ARBITER_PERF_EN
   ,
   output word_t     icount,
   output word_t     dcount
`endif
);

   arb_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   word_t            iload_q;
   word_t            dload_q;
   logic             dreq;
   logic             d_act;
   logic             i_act;
   logic             d_done;
   logic             i_done;
   logic             starve_hit;

   // A grant only drives the RAM while its requester still asks; a dropped
   // request (pipeline flush) releases the port in the same cycle.
   assign dreq       = dREN | dWEN;
   assign d_act      = (state_q == DGRANT) && dreq;
   assign i_act      = (state_q == IGRANT) && iREN;
   assign d_done     = d_act && (ramstate == ACCESS);
   assign i_done     = i_act && (ramstate == ACCESS);
   assign starve_hit = iREN && (cnt_q >= CNT_W'(STARVE_MAX));
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   // RAM-side mux: route the granted requester's request to the RAM.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (d_act) begin
         ramREN   = dREN & ~dWEN;
         ramWEN   = dWEN;
         ramaddr  = daddr;
         ramstore = dstore;
      end else if (i_act) begin
         ramREN   = 1'b1;
         ramaddr  = iaddr;
      end
   end

   assign dwait = ~d_done;
   assign iwait = ~i_done;
   assign dload = d_done ? ramload : dload_q;
   assign iload = i_done ? ramload : iload_q;

   // Grant FSM with starvation counter and load-hold registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dreq && !starve_hit) state_q <= DGRANT;
               else if (iREN)           state_q <= IGRANT;
            end
            DGRANT: begin
               if (!dreq) begin
                  state_q <= IDLE;
               end else if (ramstate == ACCESS) begin
                  state_q <= IDLE;
                  cnt_q   <= iREN ? cnt_inc : '0;
                  dload_q <= ramload;
               end
            end
            IGRANT: begin
               if (!iREN) begin
                  state_q <= IDLE;
               end else if (ramstate == ACCESS) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  iload_q <= ramload;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_PORT_ARBITER_PERF_EN
   word_t icount_q;
   word_t dcount_q;

   // Completed-access counters, wrapping at 2^32.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icount_q <= '0;
         dcount_q <= '0;
      end else begin
         if (i_done) icount_q <= icount_q + 32'd1;
         if (d_done) dcount_q <= dcount_q + 32'd1;
      end
   end

   assign icount = icount_q;
   assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_mem_port_arbiter;
   import cpu_types_pkg::*;

   localparam int SM = 3;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      ramREN, ramWEN;
   word_t     ramaddr, ramstore, ramload;
   ramstate_t ramstate;
`ifdef MEM_PORT_ARBITER_PERF_EN
   word_t     icount, dcount;
`endif

   mem_port_arbiter_if bus ();

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.STARVE_MAX(SM), .CNT_W(4)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (bus.iREN),
      .iaddr    (bus.iaddr),
      .iwait    (bus.iwait),
      .iload    (bus.iload),
      .dREN     (bus.dREN),
      .dWEN     (bus.dWEN),
      .daddr    (bus.daddr),
      .dstore   (bus.dstore),
      .dwait    (bus.dwait),
      .dload    (bus.dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
`ifdef MEM_PORT_ARBITER_PERF_EN
      ,
      .icount   (icount),
      .dcount   (dcount)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic      iren, dren, dwen;
      word_t     iaddr, daddr, dstore;
      ramstate_t rs;
      word_t     rload;
      logic      e_ren, e_wen;
      word_t     e_addr, e_store;
      logic      e_iw, e_dw;
      word_t     e_il, e_dl;
   } row_t;

   row_t tbl[18];

   function automatic row_t mk(logic iren, logic dren, logic dwen,
                               word_t ia, word_t da, word_t ds,
                               ramstate_t rs, word_t rl,
                               logic er, logic ew, word_t ea, word_t es,
                               logic eiw, logic edw, word_t eil, word_t edl);
      row_t r;
      r.iren = iren; r.dren = dren; r.dwen = dwen;
      r.iaddr = ia; r.daddr = da; r.dstore = ds;
      r.rs = rs; r.rload = rl;
      r.e_ren = er; r.e_wen = ew; r.e_addr = ea; r.e_store = es;
      r.e_iw = eiw; r.e_dw = edw; r.e_il = eil; r.e_dl = edl;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iren, input logic dren, input logic dwen,
                        input word_t ia, input word_t da, input word_t ds,
                        input ramstate_t rs, input word_t rl);
      bus.iREN   = iren;
      bus.dREN   = dren;
      bus.dWEN   = dwen;
      bus.iaddr  = ia;
      bus.daddr  = da;
      bus.dstore = ds;
      ramstate   = rs;
      ramload    = rl;
   endtask

   task automatic check(input string tag, input logic er, input logic ew,
                        input word_t ea, input word_t es, input logic eiw,
                        input logic edw, input word_t eil, input word_t edl);
      chk({tag, ".ramREN"},   32'(ramREN),    32'(er));
      chk({tag, ".ramWEN"},   32'(ramWEN),    32'(ew));
      chk({tag, ".ramaddr"},  ramaddr,        ea);
      chk({tag, ".ramstore"}, ramstore,       es);
      chk({tag, ".iwait"},    32'(bus.iwait), 32'(eiw));
      chk({tag, ".dwait"},    32'(bus.dwait), 32'(edw));
      chk({tag, ".iload"},    bus.iload,      eil);
      chk({tag, ".dload"},    bus.dload,      edl);
   endtask

   // Behavioural reference: who owns the port (0 none, 1 data, 2 instr),
   // how many data grants in a row skipped a waiting instruction read.
   int    m_owner;
   int    m_starve;
   word_t m_ih, m_dh, m_ic, m_dc;

   task automatic model_reset();
      m_owner = 0; m_starve = 0; m_ih = '0; m_dh = '0; m_ic = '0; m_dc = '0;
   endtask

   task automatic model_cycle(input string tag);
      logic  dreq, dd, id, er, ew;
      word_t ea, es;
      dreq = bus.dREN | bus.dWEN;
      dd = 1'b0; id = 1'b0; er = 1'b0; ew = 1'b0; ea = '0; es = '0;
      if (m_owner == 1 && dreq) begin
         er = bus.dREN && !bus.dWEN; ew = bus.dWEN;
         ea = bus.daddr; es = bus.dstore;
         dd = (ramstate == ACCESS);
      end else if (m_owner == 2 && bus.iREN) begin
         er = 1'b1; ea = bus.iaddr;
         id = (ramstate == ACCESS);
      end
      check(tag, er, ew, ea, es, !id, !dd, id ? ramload : m_ih, dd ? ramload : m_dh);
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk({tag, ".icount"}, icount, m_ic);
      chk({tag, ".dcount"}, dcount, m_dc);
`endif
      // What the upcoming clock edge does.
      if (m_owner == 0) begin
         if (dreq && !(bus.iREN && m_starve >= SM)) m_owner = 1;
         else if (bus.iREN) m_owner = 2;
      end else if (m_owner == 1) begin
         if (!dreq) m_owner = 0;
         else if (dd) begin
            m_owner = 0;
            m_starve = bus.iREN ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            m_dh = ramload; m_dc = m_dc + 32'd1;
         end
      end else begin
         if (!bus.iREN) m_owner = 0;
         else if (id) begin
            m_owner = 0; m_starve = 0;
            m_ih = ramload; m_ic = m_ic + 32'd1;
         end
      end
   endtask

   initial begin
      ramstate_t rs;
      int        r;

      // Directed table: single fetch, simultaneous requests, starvation.
      tbl[0]  = mk(1,0,0, 32'h40,0,0, FREE,   32'h0,        0,0,32'h0,0,           1,1, 32'h0,        32'h0);
      tbl[1]  = mk(1,0,0, 32'h40,0,0, ACCESS, 32'h8C220004, 1,0,32'h40,0,          0,1, 32'h8C220004, 32'h0);
      tbl[2]  = mk(0,0,0, 0,0,0,      FREE,   32'h0,        0,0,32'h0,0,           1,1, 32'h8C220004, 32'h0);
      tbl[3]  = mk(1,0,1, 32'h44,32'h100,32'hDEADBEEF, FREE, 32'h0, 0,0,32'h0,0,  1,1, 32'h8C220004, 32'h0);
      tbl[4]  = mk(1,0,1, 32'h44,32'h100,32'hDEADBEEF, ACCESS, 32'h11111111,
                   0,1,32'h100,32'hDEADBEEF, 1,0, 32'h8C220004, 32'h11111111);
      tbl[5]  = mk(1,0,0, 32'h44,0,0, FREE,   32'h0,        0,0,32'h0,0,           1,1, 32'h8C220004, 32'h11111111);
      tbl[6]  = mk(1,0,0, 32'h44,0,0, ACCESS, 32'h22222222, 1,0,32'h44,0,          0,1, 32'h22222222, 32'h11111111);
      tbl[7]  = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330000, 0,0,32'h0,0,     1,1, 32'h22222222, 32'h11111111);
      tbl[8]  = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330001, 1,0,32'h200,0,   1,0, 32'h22222222, 32'h33330001);
      tbl[9]  = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330009, 0,0,32'h0,0,     1,1, 32'h22222222, 32'h33330001);
      tbl[10] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330002, 1,0,32'h200,0,   1,0, 32'h22222222, 32'h33330002);
      tbl[11] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330009, 0,0,32'h0,0,     1,1, 32'h22222222, 32'h33330002);
      tbl[12] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330003, 1,0,32'h200,0,   1,0, 32'h22222222, 32'h33330003);
      tbl[13] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330009, 0,0,32'h0,0,     1,1, 32'h22222222, 32'h33330003);
      tbl[14] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330004, 1,0,32'h48,0,    0,1, 32'h33330004, 32'h33330003);
      tbl[15] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330009, 0,0,32'h0,0,     1,1, 32'h33330004, 32'h33330003);
      tbl[16] = mk(1,1,0, 32'h48,32'h200,0, ACCESS, 32'h33330005, 1,0,32'h200,0,   1,0, 32'h33330004, 32'h33330005);
      tbl[17] = mk(0,0,0, 0,0,0,      ACCESS, 32'h0,        0,0,32'h0,0,           1,1, 32'h33330004, 32'h33330005);

      // Reset state.
      nRST = 1'b0;
      drive(0,0,0, 0,0,0, FREE, 0);
      #2;
      check("reset", 0,0,0,0, 1,1, 0,0);
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("reset.icount", icount, 0);
      chk("reset.dcount", dcount, 0);
`endif
      @(negedge CLK);
      nRST = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge CLK);
         drive(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].iaddr, tbl[i].daddr,
               tbl[i].dstore, tbl[i].rs, tbl[i].rload);
         #1;
         check($sformatf("row%0d", i), tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr,
               tbl[i].e_store, tbl[i].e_iw, tbl[i].e_dw, tbl[i].e_il, tbl[i].e_dl);
      end

      // Wait states then ERROR retry on a data read.
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         rs = (c == 0) ? FREE : (c <= 4) ? BUSY : (c == 5) ? ERROR : (c == 6) ? ACCESS : FREE;
         drive(0, (c < 7), 0, 0, 32'h300, 0, rs, 32'h44440000);
         #1;
         if (c == 0)      check($sformatf("ws%0d", c), 0,0,0,0, 1,1, 32'h33330004, 32'h33330005);
         else if (c < 6)  check($sformatf("ws%0d", c), 1,0,32'h300,0, 1,1, 32'h33330004, 32'h33330005);
         else if (c == 6) check($sformatf("ws%0d", c), 1,0,32'h300,0, 1,0, 32'h33330004, 32'h44440000);
         else             check($sformatf("ws%0d", c), 0,0,0,0, 1,1, 32'h33330004, 32'h44440000);
      end

      // Request dropped mid-grant: no completion, back to IDLE.
      @(negedge CLK); drive(0,1,0, 0,32'h400,0, BUSY, 32'h55555555); #1;
      check("drop0", 0,0,0,0, 1,1, 32'h33330004, 32'h44440000);
      @(negedge CLK); drive(0,1,0, 0,32'h400,0, BUSY, 32'h55555555); #1;
      check("drop1", 1,0,32'h400,0, 1,1, 32'h33330004, 32'h44440000);
      @(negedge CLK); drive(0,0,0, 0,32'h400,0, BUSY, 32'h55555555); #1;
      check("drop2", 0,0,0,0, 1,1, 32'h33330004, 32'h44440000);
      @(negedge CLK); drive(0,1,0, 0,32'h400,0, ACCESS, 32'h55555555); #1;
      check("drop3", 0,0,0,0, 1,1, 32'h33330004, 32'h44440000);
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("drop3.icount", icount, 3);
      chk("drop3.dcount", dcount, 6);
`endif
      @(negedge CLK); drive(0,1,0, 0,32'h400,0, ACCESS, 32'h55555555); #1;
      check("drop4", 1,0,32'h400,0, 1,0, 32'h33330004, 32'h55555555);

      // Asynchronous reset while granted and waiting.
      @(negedge CLK); drive(0,1,0, 0,32'h500,0, BUSY, 0); #1;
      check("rst0", 0,0,0,0, 1,1, 32'h33330004, 32'h55555555);
      @(negedge CLK); drive(0,1,0, 0,32'h500,0, BUSY, 0); #1;
      check("rst1", 1,0,32'h500,0, 1,1, 32'h33330004, 32'h55555555);
      #1 nRST = 1'b0;
      #1;
      check("rst2", 0,0,0,0, 1,1, 0, 0);
      @(negedge CLK); nRST = 1'b1; drive(1,1,0, 32'h60,32'h500,0, FREE, 0); #1;
      check("rst3", 0,0,0,0, 1,1, 0, 0);
      @(negedge CLK); drive(1,1,0, 32'h60,32'h500,0, ACCESS, 32'h66666666); #1;
      check("rst4", 1,0,32'h500,0, 1,0, 0, 32'h66666666);

      // Randomized traffic against the reference model.
      @(negedge CLK); nRST = 1'b0; drive(0,0,0, 0,0,0, FREE, 0);
      @(negedge CLK); nRST = 1'b1;
      model_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLK);
         r  = int'($urandom_range(0, 99));
         rs = (r < 50) ? ACCESS : (r < 75) ? BUSY : (r < 85) ? FREE : ERROR;
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 3),
               $urandom, $urandom, $urandom, rs, $urandom);
         #1;
         model_cycle($sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
